// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: FIFO-buffered bytes framed onto tx at SAMPLE_RATE ticks per bit.
// Frame starts the cycle after a non-empty FIFO is seen in IDLE; data_ready drops only when the FIFO is full.
module uart_tx_sequencer #(
   parameter int SAMPLE_RATE = 16,
   parameter int DATA_BITS   = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int PARITY_EN   = 0,
   parameter int PARITY_ODD  = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                                 clock,
   input  logic                                 reset_n,
   input  logic [DATA_BITS-1:0]                 data_in,
   input  logic                                 data_valid,
   output logic                                 data_ready,
   input  logic                                 tick,
   output logic                                 start_tx,
   output logic                                 tx,
   output logic                                 busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(SAMPLE_RATE);
   localparam int BW = $clog2(DATA_BITS);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                 state;
   logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [DATA_BITS-1:0]   shift;
   logic [DATA_BITS-1:0]   frame_dat;
   logic [TW-1:0]          tick_cnt;
   logic [BW-1:0]          bit_cnt;
   logic                   stop_cnt;
   logic                   push;
   logic                   pop;
   logic                   parity_bit;

   assign data_ready = (fifo_count != CW'(FIFO_DEPTH));
   assign push       = data_valid & data_ready;
   assign pop        = (state == IDLE) && (fifo_count != '0);
   assign start_tx   = pop;
   assign busy       = (state != IDLE) || (fifo_count != '0);
   // Parity comes from the byte as popped; the shifter is consumed by then.
   assign parity_bit = (^frame_dat) ^ (PARITY_ODD != 0);

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         tx        <= 1'b1;
         shift     <= '0;
         frame_dat <= '0;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         stop_cnt  <= 1'b0;
      end else if (state == IDLE) begin
         tx <= 1'b1;
         if (pop) begin
            shift     <= mem[rd_ptr];
            frame_dat <= mem[rd_ptr];
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            tx        <= 1'b0;
            state     <= START;
         end
      end else if (tick) begin
         if (tick_cnt != TW'(SAMPLE_RATE - 1)) begin
            tick_cnt <= tick_cnt + 1'b1;
         end else begin
            tick_cnt <= '0;
            case (state)
               START: begin
                  tx      <= shift[0];
                  shift   <= shift >> 1;
                  bit_cnt <= '0;
                  state   <= DATA;
               end
               DATA: begin
                  if (bit_cnt == BW'(DATA_BITS - 1)) begin
                     stop_cnt <= 1'b0;
                     if (PARITY_EN != 0) begin
                        tx    <= parity_bit;
                        state <= PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     tx      <= shift[0];
                     shift   <= shift >> 1;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               PARITY: begin
                  tx       <= 1'b1;
                  stop_cnt <= 1'b0;
                  state    <= STOP;
               end
               STOP: begin
                  if (stop_cnt == 1'(STOP_BITS - 1))
                     state <= IDLE;
                  else
                     stop_cnt <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: three instances cover plain, even-parity and odd-parity/two-stop framing.
module tb_uart_tx_sequencer;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       tick = 1'b0;
   logic [2:0] valid_v;
   logic [2:0] rdy_v;
   logic [2:0] start_v;
   logic [2:0] tx_v;
   logic [2:0] busy_v;
   logic [7:0] din [3];
   logic [2:0] cnt [3];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int tick_period = 1;
   int starts [3] = '{0, 0, 0};
   int cons = 0;
   int rdy_low = 0;

   uart_tx_sequencer u_dut (
      .clock(clock), .reset_n(reset_n), .data_in(din[0]), .data_valid(valid_v[0]),
      .data_ready(rdy_v[0]), .tick(tick), .start_tx(start_v[0]), .tx(tx_v[0]),
      .busy(busy_v[0]), .fifo_count(cnt[0]));

   uart_tx_sequencer #(.PARITY_EN(1), .PARITY_ODD(0)) u_pe (
      .clock(clock), .reset_n(reset_n), .data_in(din[1]), .data_valid(valid_v[1]),
      .data_ready(rdy_v[1]), .tick(tick), .start_tx(start_v[1]), .tx(tx_v[1]),
      .busy(busy_v[1]), .fifo_count(cnt[1]));

   uart_tx_sequencer #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_po2 (
      .clock(clock), .reset_n(reset_n), .data_in(din[2]), .data_valid(valid_v[2]),
      .data_ready(rdy_v[2]), .tick(tick), .start_tx(start_v[2]), .tx(tx_v[2]),
      .busy(busy_v[2]), .fifo_count(cnt[2]));

   initial forever #5 clock = ~clock;

   // Tick generator: asserted 1ns after an edge so it is stable at the next one.
   initial begin
      forever begin
         @(posedge clock);
         cyc = cyc + 1;
         #1;
         if (tick_period != 0)
            tick = ((cyc % tick_period) == 0);
         else
            tick = 1'b0;
      end
   end

   initial begin
      logic [2:0] prev;
      prev = '0;
      forever begin
         @(negedge clock);
         for (int i = 0; i < 3; i++) begin
            if (start_v[i] === 1'b1) begin
               starts[i] = starts[i] + 1;
               if (prev[i]) cons = cons + 1;
            end
         end
         if (rdy_v[0] !== 1'b1) rdy_low = rdy_low + 1;
         prev = start_v;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int s, input logic [7:0] b);
      @(negedge clock);
      valid_v[s] = 1'b1;
      din[s]     = b;
      @(negedge clock);
      valid_v[s] = 1'b0;
   endtask

   // Waits for start_tx (unless the frame already started), then samples tx mid-bit.
   task automatic frame(input int s, input logic [7:0] b, input int pe, input int po,
                        input int ns, input int p, input bit started, input string tag,
                        output int t_pop);
      int n;
      int nb;
      logic [31:0] e;
      n = 0;
      if (!started) begin
         while (start_v[s] !== 1'b1 && n < 3000) begin
            @(negedge clock);
            n = n + 1;
         end
         chk({tag, "_start"}, 32'(n < 3000), 1);
         @(posedge clock);
      end
      @(negedge clock);
      t_pop = cyc;
      repeat (8 * p - 1) @(negedge clock);
      nb = 1 + 8 + pe + ns;
      for (int k = 0; k < nb; k++) begin
         if (k > 0) repeat (16 * p) @(negedge clock);
         if (k == 0)                    e = 0;
         else if (k <= 8)               e = 32'(b[k-1]);
         else if (pe != 0 && k == 9)    e = 32'((^b) ^ po[0]);
         else                           e = 1;
         chk($sformatf("%s_bit%0d", tag, k), 32'(tx_v[s]), e);
      end
   endtask

   task automatic wait_idle(input int s, input int limit);
      int n;
      n = 0;
      while (busy_v[s] !== 1'b0 && n < limit) begin
         @(negedge clock);
         n = n + 1;
      end
   endtask

   initial begin
      int tp;
      int tp1;
      int tp2;
      int s0;
      int r0;
      int low;
      reset_n = 1'b0;
      valid_v = '0;
      for (int i = 0; i < 3; i++) din[i] = '0;
      repeat (3) @(negedge clock);
      chk("rst_tx",    32'(tx_v),    32'h7);
      chk("rst_start", 32'(start_v), 0);
      chk("rst_busy",  32'(busy_v),  0);
      chk("rst_cnt",   32'(cnt[0]),  0);
      chk("rst_rdy",   32'(rdy_v),   32'h7);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // 1: single 0xA5, tick every cycle
      s0 = starts[0];
      r0 = rdy_low;
      push(0, 8'hA5);
      frame(0, 8'hA5, 0, 0, 1, 1, 1'b0, "t1", tp);
      wait_idle(0, 1000);
      chk("t1_busy_dur", 32'(cyc - tp), 160);
      chk("t1_starts",   32'(starts[0] - s0), 1);
      chk("t1_rdy_high", 32'(rdy_low - r0), 0);

      // 2: ticks stalled, overfill the FIFO
      tick_period = 0;
      repeat (3) @(negedge clock);
      s0 = starts[0];
      valid_v[0] = 1'b1;
      for (int b = 1; b <= 6; b++) begin
         din[0] = 8'(b);
         if (b == 6) begin
            chk("t2_full_rdy", 32'(rdy_v[0]), 0);
            chk("t2_full_cnt", 32'(cnt[0]), 4);
         end
         @(negedge clock);
      end
      valid_v[0] = 1'b0;
      chk("t2_cnt_hold", 32'(cnt[0]), 4);
      chk("t2_starts",   32'(starts[0] - s0), 1);
      chk("t2_tx_start", 32'(tx_v[0]), 0);
      @(posedge clock);
      tick_period = 1;
      frame(0, 8'h01, 0, 0, 1, 1, 1'b1, "t2_b1", tp);
      for (int b = 2; b <= 5; b++)
         frame(0, 8'(b), 0, 0, 1, 1, 1'b0, $sformatf("t2_b%0d", b), tp);
      wait_idle(0, 1000);
      chk("t2_empty", 32'(cnt[0]), 0);
      chk("t2_nframes", 32'(starts[0] - s0), 5);

      // 3: parity, even then odd
      push(1, 8'h07);
      frame(1, 8'h07, 1, 0, 1, 1, 1'b0, "t3e", tp);
      wait_idle(1, 1000);
      chk("t3e_dur", 32'(cyc - tp), 176);
      push(2, 8'h07);
      frame(2, 8'h07, 1, 1, 2, 1, 1'b0, "t3o", tp);
      wait_idle(2, 1000);
      chk("t3o_dur", 32'(cyc - tp), 192);

      // 4: two stop bits back to back, second byte pushed mid-frame
      s0 = starts[2];
      push(2, 8'h00);
      fork
         frame(2, 8'h00, 1, 1, 2, 1, 1'b0, "t4a", tp1);
         begin
            repeat (20) @(negedge clock);
            push(2, 8'hFF);
         end
      join
      frame(2, 8'hFF, 1, 1, 2, 1, 1'b0, "t4b", tp2);
      chk("t4_gap", 32'(tp2 - tp1), 193);
      wait_idle(2, 1000);
      chk("t4_starts", 32'(starts[2] - s0), 2);

      // 5: reset mid-DATA with two bytes buffered
      @(negedge clock);
      valid_v[0] = 1'b1;
      din[0] = 8'h11;
      @(negedge clock);
      din[0] = 8'h22;
      @(negedge clock);
      din[0] = 8'h33;
      @(negedge clock);
      valid_v[0] = 1'b0;
      repeat (50) @(negedge clock);
      chk("t5_pre_cnt",  32'(cnt[0]), 2);
      chk("t5_pre_busy", 32'(busy_v[0]), 1);
      reset_n = 1'b0;
      #1;
      chk("t5_tx",    32'(tx_v[0]), 1);
      chk("t5_busy",  32'(busy_v[0]), 0);
      chk("t5_cnt",   32'(cnt[0]), 0);
      chk("t5_start", 32'(start_v[0]), 0);
      @(negedge clock);
      reset_n = 1'b1;
      s0 = starts[0];
      low = 0;
      repeat (400) begin
         @(negedge clock);
         if (tx_v[0] !== 1'b1) low = low + 1;
      end
      chk("t5_no_start", 32'(starts[0] - s0), 0);
      chk("t5_tx_idle",  32'(low), 0);
      chk("t5_idle",     32'(busy_v[0]), 0);

      // 6: tick every third cycle, ticks ignored while idle
      tick_period = 3;
      s0 = starts[0];
      repeat (30) @(negedge clock);
      chk("t6_idle_tx",    32'(tx_v[0]), 1);
      chk("t6_idle_busy",  32'(busy_v[0]), 0);
      chk("t6_idle_start", 32'(starts[0] - s0), 0);
      push(0, 8'h5A);
      frame(0, 8'h5A, 0, 0, 1, 3, 1'b0, "t6", tp);
      wait_idle(0, 2000);
      chk("t6_dur", 32'((cyc - tp) >= 478 && (cyc - tp) <= 480), 1);

      chk("start_never_consecutive", 32'(cons), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
